ieee_to_flopoco_ingress: RTL and testbench

//  Upstream feeder for the FloPoCo fsqrt core (wE=4, wF=4, 11-bit FloPoCo word).
//  - Accepts packed IEEE-style floats {sign, exp[WE-1:0], frac[WF-1:0]} on a valid/ready stream.
//  - Classifies each value and rewrites it into FloPoCo format {exn[1:0], sign, exp, frac}.
//  - Registers the result behind a 2-entry skid buffer, so the free-running, unhandshaked

---
 rtl/fp_fmt_pkg.sv | 62 ++++++
 rtl/ieee_to_flopoco_ingress_if.sv | 11 +
 rtl/fp_skid_buf.sv | 74 +++++++
 rtl/ieee_to_flopoco_ingress.sv | 70 +++++++
 tb/tb_ieee_to_flopoco_ingress.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/fp_fmt_pkg.sv
// Shared number-format definitions for the FloPoCo fsqrt ingress/egress path.
package fp_fmt_pkg;

   localparam int unsigned WE = 4;
   localparam int unsigned WF = 4;

   localparam logic [1:0] EXN_ZERO = 2'b00;
   localparam logic [1:0] EXN_NORM = 2'b01;
   localparam logic [1:0] EXN_INF  = 2'b10;
   localparam logic [1:0] EXN_NAN  = 2'b11;

   typedef struct packed {
      logic          sign;
      logic [WE-1:0] exp;
      logic [WF-1:0] frac;
   } ieee_t;

   typedef struct packed {
      logic [1:0]    exn;
      logic          sign;
      logic [WE-1:0] exp;
      logic [WF-1:0] frac;
   } flopoco_t;

   // Occupancy of the 2-entry skid buffer; bit 0 = main full, bit 1 = skid full.
   typedef enum logic [1:0] {
      SKID_EMPTY = 2'b00,
      SKID_MAIN  = 2'b01,
      SKID_FULL  = 2'b11
   } skid_state_e;

   // IEEE and FloPoCo share the exponent bias, so normal values copy through.
   function automatic flopoco_t ieee_to_flopoco(input ieee_t w);
      flopoco_t r;
      r      = '0;
      r.sign = w.sign;
      if (w.exp == '0) begin
         r.exn = EXN_ZERO;
      end else if (w.exp == '1) begin
         if (w.frac == '0) begin
            r.exn = EXN_INF;
         end else begin
            r.exn  = EXN_NAN;
            r.sign = 1'b0;
         end
      end else begin
         r.exn  = EXN_NORM;
         r.exp  = w.exp;
         r.frac = w.frac;
      end
      return r;
   endfunction

   function automatic logic is_subnormal(input ieee_t w);
      return (w.exp == '0) && (w.frac != '0);
   endfunction

   function automatic logic is_nan(input ieee_t w);
      return (w.exp == '1) && (w.frac != '0);
   endfunction

endpackage

// File: rtl/ieee_to_flopoco_ingress_if.sv
// Generic valid/ready stream bundle.
interface ieee_to_flopoco_ingress_if #(
   parameter int unsigned W = 9
) ();
   logic         valid;
   logic         ready;
   logic [W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fp_skid_buf.sv
// Two-entry valid/ready skid buffer; in_ready is a pure register decode.
module fp_skid_buf
   import fp_fmt_pkg::*;
#(
   parameter int unsigned W = 11
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   skid_state_e  state_q, state_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         accept;
   logic         drain;

   assign in_ready  = (state_q != SKID_FULL);
   assign out_valid = (state_q != SKID_EMPTY);
   assign out_data  = main_q;
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;

   // Next occupancy and data movement: fill main first, spill to skid on stall.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         SKID_EMPTY: begin
            if (accept) begin
               main_d  = in_data;
               state_d = SKID_MAIN;
            end
         end
         SKID_MAIN: begin
            if (accept && drain) begin
               main_d = in_data;
            end else if (accept) begin
               skid_d  = in_data;
               state_d = SKID_FULL;
            end else if (drain) begin
               state_d = SKID_EMPTY;
            end
         end
         SKID_FULL: begin
            if (drain) begin
               main_d  = skid_q;
               state_d = SKID_MAIN;
            end
         end
         default: state_d = SKID_EMPTY;
      endcase
   end

   // State and data registers; reset discards any buffered words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SKID_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: rtl/ieee_to_flopoco_ingress.sv
// IEEE-style to FloPoCo converter feeding the fsqrt core through a skid buffer,
// with saturating counters for flushed subnormals and NaNs.
module ieee_to_flopoco_ingress
   import fp_fmt_pkg::*;
#(
   parameter int unsigned WE    = 4,
   parameter int unsigned WF    = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   ieee_to_flopoco_ingress_if.slave     in_if,
   ieee_to_flopoco_ingress_if.master    out_if,
   input  logic                         stat_clr,
   output logic [CNT_W-1:0]             flush_cnt,
   output logic [CNT_W-1:0]             nan_cnt
);

   logic [WE+WF:0]   in_word;
   logic [WE+WF+2:0] conv_word;
   ieee_t            in_fp;
   logic             accept;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] nan_cnt_q, nan_cnt_d;

   assign in_word   = in_if.data;
   assign in_fp     = ieee_t'(in_word);
   assign conv_word = ieee_to_flopoco(in_fp);
   assign accept    = in_if.valid && in_if.ready;
   assign flush_cnt = flush_cnt_q;
   assign nan_cnt   = nan_cnt_q;

   fp_skid_buf #(
      .W (3 + WE + WF)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_if.valid),
      .in_ready  (in_if.ready),
      .in_data   (conv_word),
      .out_valid (out_if.valid),
      .out_ready (out_if.ready),
      .out_data  (out_if.data)
   );

   // Counter update: clear wins over increment, increments saturate at all-ones.
   always_comb begin
      flush_cnt_d = flush_cnt_q;
      nan_cnt_d   = nan_cnt_q;
      if (stat_clr) begin
         flush_cnt_d = '0;
         nan_cnt_d   = '0;
      end else if (accept) begin
         if (is_subnormal(in_fp) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
         if (is_nan(in_fp) && (nan_cnt_q != '1))         nan_cnt_d   = nan_cnt_q + CNT_W'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt_q <= '0;
         nan_cnt_q   <= '0;
      end else begin
         flush_cnt_q <= flush_cnt_d;
         nan_cnt_q   <= nan_cnt_d;
      end
   end

endmodule

// File: tb/tb_ieee_to_flopoco_ingress.sv
// Scoreboard bench for ieee_to_flopoco_ingress: driver pushes expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_ieee_to_flopoco_ingress;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       stat_clr = 1'b0;
   logic [3:0] flush_cnt;
   logic [3:0] nan_cnt;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [10:0] exp_q[$];
   bit         rand_rdy = 1'b0;
   int         n_sub = 0;
   int         n_nan = 0;

   ieee_to_flopoco_ingress_if #(.W(9))  in_if ();
   ieee_to_flopoco_ingress_if #(.W(11)) out_if ();

   ieee_to_flopoco_ingress #(
      .WE    (4),
      .WF    (4),
      .CNT_W (4)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_if     (in_if),
      .out_if    (out_if),
      .stat_clr  (stat_clr),
      .flush_cnt (flush_cnt),
      .nan_cnt   (nan_cnt)
   );

   always #5 clk = ~clk;

   // Reference conversion written independently from the design.
   function automatic logic [10:0] model(input logic [8:0] x);
      logic [3:0] e;
      logic [3:0] f;
      e = x[7:4];
      f = x[3:0];
      if (e == 4'hF) return (f != 4'h0) ? 11'h600 : {2'b10, x[8], 8'h00};
      if (e == 4'h0) return {2'b00, x[8], 8'h00};
      return {2'b01, x};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   // Monitor: a handshake seen at negedge completes at the following posedge.
   always @(negedge clk) begin
      if (rst_n && out_if.valid && out_if.ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_unexpected: got %0h expected no word", out_if.data);
         end else begin
            chk("out_data", {21'd0, out_if.data}, {21'd0, exp_q.pop_front()});
         end
      end
   end

   // Random downstream backpressure.
   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         out_if.ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic send(input logic [8:0] d);
      int unsigned t;
      t = 0;
      in_if.valid = 1'b1;
      in_if.data  = d;
      forever begin
         @(negedge clk);
         if (in_if.ready) break;
         t++;
         if (t > 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected accept", t);
            in_if.valid = 1'b0;
            return;
         end
      end
      exp_q.push_back(model(d));
      @(posedge clk);
      #1;
      in_if.valid = 1'b0;
   endtask

   task automatic wait_drain();
      int unsigned t;
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("drain_left", exp_q.size(), 0);
   endtask

   task automatic clr_stats();
      stat_clr = 1'b1;
      @(posedge clk);
      #1;
      stat_clr = 1'b0;
   endtask

   initial begin
      logic [8:0] d;
      int         nw;
      in_if.valid  = 1'b0;
      in_if.data   = '0;
      out_if.ready = 1'b0;

      // Reset state.
      #2;
      chk("rst_in_ready", in_if.ready, 1);
      chk("rst_out_valid", out_if.valid, 0);
      chk("rst_out_data", out_if.data, 0);
      chk("rst_flush", flush_cnt, 0);
      chk("rst_nan", nan_cnt, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic conversions.
      out_if.ready = 1'b1;
      send(9'h070);
      chk("t1_valid", out_if.valid, 1);
      chk("t1_data", out_if.data, 11'h270);
      send(9'h0F0);
      send(9'h1F0);
      send(9'h100);
      send(9'h0F1);
      send(9'h1F5);
      chk("t3_nan_cnt", nan_cnt, 2);
      send(9'h005);
      chk("t4_flush_cnt", flush_cnt, 1);
      send(9'h081);
      chk("t5_data", out_if.data, 11'h281);
      wait_drain();

      // Stall: main then skid fill, in_ready drops, then drains in order.
      out_if.ready = 1'b0;
      send(9'h035);
      chk("t6_rdy_after1", in_if.ready, 1);
      send(9'h1A2);
      chk("t6_rdy_after2", in_if.ready, 0);
      in_if.valid = 1'b1;
      in_if.data  = 9'h0F3;
      repeat (3) @(posedge clk);
      #1;
      chk("t6_stall_rdy", in_if.ready, 0);
      chk("t6_hold_data", out_if.data, model(9'h035));
      out_if.ready = 1'b1;
      send(9'h0F3);
      wait_drain();

      // Random traffic with random backpressure.
      clr_stats();
      chk("t7_clr_flush", flush_cnt, 0);
      chk("t7_clr_nan", nan_cnt, 0);
      rand_rdy = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         nw = $urandom_range(0, 2);
         repeat (nw) @(posedge clk);
         if (nw != 0) #1;
         d = 9'($urandom);
         if (d[7:4] == 4'h0 && d[3:0] != 4'h0) n_sub++;
         if (d[7:4] == 4'hF && d[3:0] != 4'h0) n_nan++;
         send(d);
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      #2;
      out_if.ready = 1'b1;
      wait_drain();
      chk("t7_flush_sat", flush_cnt, (n_sub > 15) ? 15 : n_sub);
      chk("t7_nan_sat", nan_cnt, (n_nan > 15) ? 15 : n_nan);

      // Saturation and clear-vs-increment priority.
      clr_stats();
      for (int i = 1; i <= 15; i++) send({5'h00, 4'(i)});
      chk("t8_flush_15", flush_cnt, 15);
      send(9'h10F);
      chk("t8_flush_sat", flush_cnt, 15);
      stat_clr = 1'b1;
      send(9'h002);
      stat_clr = 1'b0;
      chk("t8_clr_prio", flush_cnt, 0);
      wait_drain();

      // Asynchronous reset with the skid full.
      out_if.ready = 1'b0;
      send(9'h070);
      send(9'h0F5);
      chk("t8_skid_full", in_if.ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t8_rst_valid", out_if.valid, 0);
      chk("t8_rst_ready", in_if.ready, 1);
      chk("t8_rst_data", out_if.data, 0);
      chk("t8_rst_nan", nan_cnt, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_if.ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t8_no_stale", out_if.valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
